// File: rtl/delay_probe_pkg.sv
// Shared types and constants for the delay-line latency prober.
// Contents: FSM state enum, the idle fill byte, the default marker byte,
// and a helper that maps a state to its busy indication.
package delay_probe_pkg;

   localparam int unsigned BYTE_W = 8;

   // Byte driven into the line while flushing and while waiting for the marker
   localparam logic [BYTE_W-1:0] IDLE_BYTE      = 8'h00;
   // Default probe byte; must differ from IDLE_BYTE
   localparam logic [BYTE_W-1:0] DEFAULT_MARKER = 8'hA5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLUSH  = 2'd1,
      LAUNCH = 2'd2,
      WAIT   = 2'd3
   } probe_state_e;

   // Every state except IDLE belongs to an active measurement
   function automatic logic state_is_busy(input probe_state_e st);
      return (st != IDLE);
   endfunction

endpackage

// File: rtl/probe_cycle_counter.sv
// Saturating up-counter shared by the flush and wait phases of the prober.
// Ports:
//   clock_i  - system clock, rising edge
//   reset_i  - synchronous active-high reset (count -> 0)
//   clr_i    - synchronous clear, takes priority over enable
//   en_i     - increment enable; the count sticks at all-ones
//   count_o  - current count
module probe_cycle_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins, then saturating increment
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/delay_line_prober.sv
// Latency-measurement stage wrapped around an 8-bit delay line.
// In IDLE the user byte passes straight to the line. A start request flushes
// the line with IDLE_BYTE for FLUSH_LEN cycles, launches MARKER for one
// cycle, then counts WAIT cycles until the marker returns or the wait
// budget runs out.
// Optional build macro: DELAY_PROBE_CHECK_EN adds the sticky `corrupt`
// output flagging unexpected bytes seen on the line while waiting.
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous active-high reset
//   start        - measurement request, honoured only in IDLE
//   pass_data_i  - user byte forwarded to the line in IDLE
//   line_data_o  - byte fed to the delay-line input (combinational from state)
//   line_data_i  - byte returned from the delay-line output
//   busy         - high while flushing, launching or waiting
//   done         - one-cycle pulse when a result is written
//   timeout      - sticky, last measurement gave up
//   corrupt      - (DELAY_PROBE_CHECK_EN only) sticky, stray byte seen in WAIT
//   latency      - last measured latency, all-ones after a timeout
module delay_line_prober
   import delay_probe_pkg::*;
#(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       CNT_W       = 8,
   parameter int unsigned       FLUSH_LEN   = 64,
   parameter int unsigned       TIMEOUT_CYC = 200,
   parameter logic [DATA_W-1:0] MARKER      = DATA_W'(DEFAULT_MARKER)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] pass_data_i,
   output logic [DATA_W-1:0] line_data_o,
   input  logic [DATA_W-1:0] line_data_i,
   output logic              busy,
   output logic              done,
   output logic              timeout,
`ifdef DELAY_PROBE_CHECK_EN
   output logic              corrupt,
`endif
   output logic [CNT_W-1:0]  latency
);

   localparam logic [DATA_W-1:0] FILL_BYTE  = DATA_W'(IDLE_BYTE);
   localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
   localparam logic [CNT_W-1:0]  WAIT_LIMIT = CNT_W'(TIMEOUT_CYC);

   probe_state_e     state_q;
   logic             busy_q;
   logic             done_q;
   logic             timeout_q;
   logic [CNT_W-1:0] latency_q;

   logic [CNT_W-1:0] cnt;
   logic             cnt_clr;
   logic             cnt_en;
   logic             marker_hit;
   logic             flush_last;
   logic             wait_expired;

   assign marker_hit   = (line_data_i == MARKER);
   assign flush_last   = (cnt == FLUSH_LAST);
   assign wait_expired = (cnt == WAIT_LIMIT);

   probe_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clock_i (clock),
      .reset_i (reset),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (cnt)
   );

   // Counter control. LAUNCH bumps the cleared count to 1 so that the first
   // WAIT cycle already represents one cycle of line latency.
   always_comb begin
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE:    cnt_clr = start;
         FLUSH: begin
            if (flush_last) begin
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         LAUNCH:  cnt_en = 1'b1;
         WAIT:    cnt_en = !marker_hit && !wait_expired;
         default: cnt_clr = 1'b0;
      endcase
   end

   // Line drive selected by phase
   always_comb begin
      line_data_o = pass_data_i;
      case (state_q)
         IDLE:    line_data_o = pass_data_i;
         FLUSH:   line_data_o = FILL_BYTE;
         LAUNCH:  line_data_o = MARKER;
         WAIT:    line_data_o = FILL_BYTE;
         default: line_data_o = pass_data_i;
      endcase
   end

   // Measurement FSM with registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         latency_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= FLUSH;
                  timeout_q <= 1'b0;
               end
            end
            FLUSH: begin
               if (flush_last) begin
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               state_q <= WAIT;
            end
            WAIT: begin
               // A match on the final allowed cycle still counts as a match
               if (marker_hit) begin
                  latency_q <= cnt;
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end else if (wait_expired) begin
                  latency_q <= '1;
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         // busy mirrors the state being entered so it lines up with state_q
         case (state_q)
            IDLE:    busy_q <= start;
            WAIT:    busy_q <= !(marker_hit || wait_expired);
            default: busy_q <= state_is_busy(state_q);
         endcase
      end
   end

`ifdef DELAY_PROBE_CHECK_EN
   logic corrupt_q;

   // Sticky flag for any byte in WAIT that is neither fill nor marker
   always_ff @(posedge clock) begin
      if (reset) begin
         corrupt_q <= 1'b0;
      end else if ((state_q == IDLE) && start) begin
         corrupt_q <= 1'b0;
      end else if ((state_q == WAIT) && (line_data_i != FILL_BYTE) && !marker_hit) begin
         corrupt_q <= 1'b1;
      end
   end

   assign corrupt = corrupt_q;
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign timeout = timeout_q;
   assign latency = latency_q;

endmodule

// File: doc/delay_line_prober.md
Name: delay_line_prober

Overview:
- Latency-measurement stage wrapped around the 8-bit delay line.
- Drives the line's data input (upstream side) and watches its output (downstream side).
- In normal mode it passes the user byte straight through to the line. On a start request it flushes the line, launches a marker byte, then counts cycles until the marker emerges.
- Reports the measured latency, or a timeout.

Parameters:
- DATA_W, 8, width of the line data bytes.
- CNT_W, 8, width of the latency counter and result.
- FLUSH_LEN, 64, number of cycles IDLE_BYTE is driven before the marker is launched.
- TIMEOUT_CYC, 200, WAIT cycles before giving up; must be < 2^CNT_W - 1.
- MARKER, 8'hA5, probe byte; must differ from IDLE_BYTE.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a measurement; sampled only in IDLE.
- pass_data_i  in  DATA_W  user byte forwarded in IDLE.
- line_data_o  out  DATA_W  byte fed to the delay-line input.
- line_data_i  in  DATA_W  byte returned from the delay-line output.
- busy  out  1  high in FLUSH, LAUNCH and WAIT.
- done  out  1  one-cycle pulse when a result (match or timeout) is written.
- timeout  out  1  sticky; last measurement failed.
- latency  out  CNT_W  last measured latency; all-ones on timeout.

Behaviour:
- Interface (already decided): one clock, `clock`; synchronous active-high reset, `reset`.
- Reset values: state=IDLE, counter=0, busy=0, done=0, timeout=0, latency=0. A reset mid-measurement aborts it with no done pulse.
- line_data_o is combinational from state:
  - IDLE -> pass_data_i.
  - FLUSH -> IDLE_BYTE (8'h00).
  - LAUNCH -> MARKER.
  - WAIT -> IDLE_BYTE.
- IDLE:
  - start=1 -> FLUSH, counter<=0, timeout<=0.
  - start in any other state is ignored.
- FLUSH:
  - counter increments each cycle.
  - When counter==FLUSH_LEN-1 -> LAUNCH, counter<=0.
- LAUNCH: lasts exactly one cycle (marker on line_data_o in cycle t) -> WAIT, counter<=1.
- WAIT:
  - Each cycle compares line_data_i to MARKER.
  - On match in cycle t+N: latency<=N (the counter value), done<=1 for one cycle -> IDLE.
  - Without a match, counter increments.
  - When counter==TIMEOUT_CYC with no match: latency<=all-ones, timeout<=1, done<=1 -> IDLE.
- Simultaneous match and timeout in the same cycle: the match wins.
- Counter saturates at all-ones and never wraps.
- latency and timeout hold until the next accepted start; timeout also clears on that start.
- A delay line of pure latency N reports latency==N for 1 <= N <= TIMEOUT_CYC.
- N=0 (combinational loop-back) cannot match in WAIT and reports a timeout.

Optional Feature:
- Macro: DELAY_PROBE_CHECK_EN.
- When defined:
  - Adds output port `corrupt` (1 bit, reset 0).
  - In WAIT, any line_data_i that is neither IDLE_BYTE nor MARKER sets `corrupt`.
  - `corrupt` is sticky and clears on the next accepted start.
  - Measurement continues regardless.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package delay_probe_pkg holds:
  - state enum {IDLE, FLUSH, LAUNCH, WAIT};
  - IDLE_BYTE constant 8'h00;
  - default MARKER 8'hA5.
- One natural sub-module: probe_cycle_counter, a saturating CNT_W counter with synchronous clear and enable, shared by FLUSH and WAIT.

Test Plan:
- Passthrough: idle, pass_data_i=8'h3C -> line_data_o=8'h3C the same cycle; busy=0, done=0.
- Nominal measure: bench models a 60-cycle delay line; pulse start -> busy for 64+1+60 cycles, then done pulses once, latency=60, timeout=0.
- Timeout: line_data_i held at 8'h00 -> after TIMEOUT_CYC WAIT cycles, done pulses, latency=8'hFF, timeout=1; the next start clears timeout.
- Boundary: delay N=200 (==TIMEOUT_CYC) -> match wins, latency=200, timeout=0; delay N=1 -> latency=1.
- Reset mid-WAIT: assert reset at WAIT cycle 10 -> next cycle IDLE, busy=0, latency=0, no done pulse. start while busy is ignored (result unchanged).
- With DELAY_PROBE_CHECK_EN: inject 8'h77 at WAIT cycle 5 on a 60-cycle line -> corrupt=1, latency=60 still reported.
